alu_control_muldiv: RTL and testbench
=====================================

// Module: alu_control_muldiv
// PURPOSE
//  Next-generation ALU control for the datapath. Decodes ALUOP + funct into the 4-bit ALU select and
//  sequences iterative multi-cycle MULT/MULTU/DIV/DIVU into HI/LO, stalling the pipeline via busy.
//  Sits between main control/ID stage and the ALU; HI/LO feed the mfhi/mflo writeback mux.
// PARAMETERS
//  WIDTH   32  operand/HI/LO width in bits (>=4); iterative ops take WIDTH cycles
// PORTS
//  clock     in   1      rising-edge clock
//  reset     in   1      asynchronous, active-high reset
//  ALUOP     in   2      from main control: 00 add, 01 sub, 10 R-type (use funct), 11 reserved
//  funct     in   6      instruction[5:0]
//  start     in   1      issue strobe; accepted only when idle/done and a mul/div is decoded
//  op_a      in   WIDTH  rs operand (multiplicand / dividend), sampled on accept
//  op_b      in   WIDTH  rt operand (multiplier / divisor), sampled on accept
//  alu_ctrl  out  4      ALU select (combinational)
//  illegal   out  1      ALUOP/funct combination not recognised (combinational)
//  busy      out  1      iterative op in progress; pipeline must stall
//  done      out  1      one-cycle pulse: HI/LO just updated
//  hi        out  WIDTH  product high half / remainder
//  lo        out  WIDTH  product low half / quotient
// BEHAVIOUR
//  Decode (combinational): ALUOP 00 -> 0010; 01 -> 0110; 10 with funct[3:0] 0000->0010, 0010->0110,
//   0100->0000, 0101->0001, 1010->0111 (funct[5:4]=10); funct 0110xx -> 0010 (ALU idle, mul/div path);
//   any other 10/funct or ALUOP 11 -> 1111 with illegal=1. No latch, every input covered.
//  Mul/div funct: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
//  FSM: IDLE -> RUN on accept (start & ALUOP==10 & funct mul/div); RUN counts WIDTH cycles -> DONE;
//   DONE lasts 1 cycle -> IDLE, or -> RUN if a new accept occurs in the DONE cycle (back-to-back).
//  Timing: accept at edge T; busy=1 for cycles T+1..T+WIDTH; done=1 and hi/lo valid in cycle T+WIDTH+1,
//   busy=0 in that cycle. start while busy is ignored (no queueing). start with non-mul/div funct ignored.
//  Multiply: shift-add, 2*WIDTH-bit product {hi,lo}. Divide: restoring, lo=quotient, hi=remainder.
//  Divide by zero: lo = all ones, hi = op_a as sampled; still takes WIDTH cycles and pulses done.
//  hi/lo hold their value between ops; only written in the DONE transition.
//  Reset (any time, incl. mid-op): state IDLE, counter 0, busy=0, done=0, hi=0, lo=0; aborted op
//   produces no done and no HI/LO write.
// CONFIGURATION
//  SIGNED_MULDIV_EN defined: MULT/DIV take magnitudes at accept and fix signs at DONE: product negated
//   if operand signs differ; quotient negated if signs differ; remainder takes dividend sign.
//   Div-by-zero result unchanged (no sign correction).
//  Not defined: MULT/DIV execute exactly as MULTU/DIVU; illegal stays 0 for them.
// STRUCTURE
//  Package alu_ctrl_pkg: ALU select localparams (ALU_AND/OR/ADD/SUB/SLT/BAD), ALUOP codes, funct codes
//   (F_ADD..F_SLT, F_MULT/F_MULTU/F_DIV/F_DIVU), FSM state encoding (S_IDLE/S_RUN/S_DONE).
//  Sub-module muldiv_iter: iterative datapath (accumulator, shift regs, counter, sign fix-up);
//   top holds decode, FSM, handshake and HI/LO registers.
// TESTING (WIDTH=32)
//  1 Decode sweep: ALUOP 00/01 any funct -> 0010/0110; 10 with 100000,100010,100100,100101,101010 ->
//    0010,0110,0000,0001,0111; 10/000111 and ALUOP 11 -> 1111, illegal=1.
//  2 MULTU 0xFFFFFFFF*2, start at T -> busy T+1..T+32, done at T+33, hi=0x1, lo=0xFFFFFFFE;
//    start pulses during busy ignored; back-to-back accept in DONE cycle starts next op.
//  3 DIVU 7/2 -> lo=3, hi=1; DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, done still at T+33.
//  4 DIV -7/2 (0xFFFFFFF9/2): with SIGNED_MULDIV_EN lo=0xFFFFFFFD, hi=0xFFFFFFFF;
//    MULT -3*4 -> hi=0xFFFFFFFF lo=0xFFFFFFF4. Without macro DIV -> lo=0x7FFFFFFC, hi=1.
//  5 Assert reset at T+10 of a MULTU with hi/lo holding 0x1234: busy/done/hi/lo=0 immediately,
//    no done pulse afterwards; new op after release completes normally.

Source files
------------

// File: rtl/alu_control_muldiv_pkg.sv
// Shared encodings for the ALU control / iterative mul-div block: ALU selects,
// ALUOP and funct codes, FSM states.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_RSVD  = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/alu_control_muldiv_if.sv
// Bus between main control / ID stage and the ALU control block: decode inputs,
// mul/div issue handshake and HI/LO results.
interface alu_control_muldiv_if #(parameter int unsigned WIDTH = 32);
  logic [1:0]       ALUOP;
  logic [5:0]       funct;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       alu_ctrl;
  logic             illegal;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output ALUOP, funct, start, op_a, op_b,
                  input  alu_ctrl, illegal, busy, done, hi, lo);
  modport slave  (input  ALUOP, funct, start, op_a, op_b,
                  output alu_ctrl, illegal, busy, done, hi, lo);
endinterface

// File: rtl/alu_control_muldiv_muldiv_iter.sv
// Iterative datapath: one shift-add multiply or restoring divide step per cycle,
// magnitude load on start and sign fix-up applied to the final-step result.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   acc_q, sh_q, opb_q;
  logic               div_q, neg_q, rneg_q;
  logic [CW-1:0]      cnt_q;
  logic               div_zero, a_neg, b_neg, ge;
  logic [WIDTH-1:0]   a_ld, b_ld, acc_d, sh_d;
  logic [WIDTH:0]     sum, trial;
  logic [2*WIDTH-1:0] prod;

  // A zero divisor keeps the raw dividend and no sign flags, so the plain
  // restoring loop naturally yields quotient all-ones and remainder = op_a.
  always_comb begin
    div_zero = is_div_i && (b_i == '0);
    a_neg    = is_signed_i && a_i[WIDTH-1] && !div_zero;
    b_neg    = is_signed_i && b_i[WIDTH-1];
    a_ld     = a_neg ? -a_i : a_i;
    b_ld     = b_neg ? -b_i : b_i;
  end

  always_comb begin
    sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
    trial = {acc_q, sh_q[WIDTH-1]};
    ge    = trial >= {1'b0, opb_q};
    if (div_q) begin
      acc_d = ge ? (trial[WIDTH-1:0] - opb_q) : trial[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], ge};
    end else begin
      acc_d = sum[WIDTH:1];
      sh_d  = {sum[0], sh_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod = neg_q ? -{acc_d, sh_d} : {acc_d, sh_d};
    hi_o = prod[2*WIDTH-1:WIDTH];
    lo_o = prod[WIDTH-1:0];
    if (div_q) begin
      hi_o = rneg_q ? -acc_d : acc_d;
      lo_o = neg_q  ? -sh_d  : sh_d;
    end
  end

  assign last_o = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      sh_q   <= '0;
      opb_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
    end else if (load_i) begin
      acc_q  <= '0;
      sh_q   <= a_ld;
      opb_q  <= b_ld;
      div_q  <= is_div_i;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      cnt_q  <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_control_muldiv.sv
// ALU control: ALUOP/funct decode plus multi-cycle MULT/MULTU/DIV/DIVU into HI/LO.
// Define SIGNED_MULDIV_EN to give MULT/DIV signed semantics.
module alu_control_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  alu_control_muldiv_if.slave  bus
);

  logic [3:0]       alu_sel;
  logic             bad_op;
  logic             mul_div, accept, signed_op, step, last;
  logic [WIDTH-1:0] res_hi, res_lo;
  state_t           state_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  always_comb begin
    alu_sel = ALU_BAD;
    bad_op  = 1'b1;
    case (bus.ALUOP)
      AOP_ADD: begin alu_sel = ALU_ADD; bad_op = 1'b0; end
      AOP_SUB: begin alu_sel = ALU_SUB; bad_op = 1'b0; end
      AOP_RTYPE: begin
        bad_op = 1'b0;
        if (is_muldiv(bus.funct)) begin
          alu_sel = ALU_ADD;
        end else begin
          case (bus.funct)
            F_ADD:   alu_sel = ALU_ADD;
            F_SUB:   alu_sel = ALU_SUB;
            F_AND:   alu_sel = ALU_AND;
            F_OR:    alu_sel = ALU_OR;
            F_SLT:   alu_sel = ALU_SLT;
            default: begin alu_sel = ALU_BAD; bad_op = 1'b1; end
          endcase
        end
      end
      default: begin alu_sel = ALU_BAD; bad_op = 1'b1; end
    endcase
  end

  assign bus.alu_ctrl = alu_sel;
  assign bus.illegal  = bad_op;

  assign mul_div = (bus.ALUOP == AOP_RTYPE) && is_muldiv(bus.funct);
  assign accept  = bus.start && mul_div && (state_q != S_RUN);
  assign step    = (state_q == S_RUN);

`ifdef SIGNED_MULDIV_EN
  assign signed_op = !bus.funct[0];
`else
  assign signed_op = 1'b0;
`endif

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk        (clock),
    .rst        (reset),
    .load_i     (accept),
    .step_i     (step),
    .is_div_i   (bus.funct[1]),
    .is_signed_i(signed_op),
    .a_i        (bus.op_a),
    .b_i        (bus.op_b),
    .last_o     (last),
    .hi_o       (res_hi),
    .lo_o       (res_lo)
  );

  // HI/LO take the final-step result on the RUN->DONE edge, so done and
  // valid data appear together in the DONE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          if (last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= res_hi;
            lo_q    <= res_lo;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Self-checking bench for alu_control_muldiv (WIDTH=32) against an arithmetic
// reference model; honours SIGNED_MULDIV_EN when defined.
module tb_alu_control_muldiv;

  localparam int unsigned W = 32;
`ifdef SIGNED_MULDIV_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_control_muldiv_if #(.WIDTH(W)) bus ();

  alu_control_muldiv #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] ref_dec(input logic [1:0] aop, input logic [5:0] f);
    case (aop)
      2'b00: return 5'b0_0010;
      2'b01: return 5'b0_0110;
      2'b10: begin
        case (f)
          6'b100000: return 5'b0_0010;
          6'b100010: return 5'b0_0110;
          6'b100100: return 5'b0_0000;
          6'b100101: return 5'b0_0001;
          6'b101010: return 5'b0_0111;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: return 5'b0_0010;
          default:   return 5'b1_1111;
        endcase
      end
      default: return 5'b1_1111;
    endcase
  endfunction

  // Returns {hi, lo}
  function automatic logic [63:0] ref_muldiv(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, sq, sr;
    logic [63:0] up;
    logic       sgn;
    sgn = SIGNED_EN && !f[0];
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    if (!f[1]) begin
      if (sgn) begin
        sq = sa * sb;
        return sq;
      end
      up = {32'h0, a} * {32'h0, b};
      return up;
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.ALUOP = 2'b10;
    bus.funct = f;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  // Entered one step after the accepting edge; leaves in the done cycle.
  task automatic wait_result(input string name, input logic [31:0] eh, input logic [31:0] el, input bit noise);
    for (int unsigned i = 0; i < W; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy cycle %0d: busy=%b done=%b, expected busy=1 done=0", name, i + 1, bus.busy, bus.done);
      end
      if (noise && i < W - 1) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.funct = {4'b0110, 2'($urandom_range(0, 3))};
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clock);
      #1;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done cycle: busy=%b done=%b, expected busy=0 done=1", name, bus.busy, bus.done);
    end
    checks++;
    if (bus.hi !== eh) begin
      errors++;
      $display("FAIL %s hi: got %h expected %h", name, bus.hi, eh);
    end
    checks++;
    if (bus.lo !== el) begin
      errors++;
      $display("FAIL %s lo: got %h expected %h", name, bus.lo, el);
    end
  endtask

  task automatic check_hold(input string name, input logic [31:0] eh, input logic [31:0] el);
    @(posedge clock);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== eh || bus.lo !== el) begin
      errors++;
      $display("FAIL %s hold: busy=%b done=%b hi=%h lo=%h, expected 0 0 %h %h",
               name, bus.busy, bus.done, bus.hi, bus.lo, eh, el);
    end
  endtask

  task automatic model_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit noise, output logic [63:0] r);
    r = ref_muldiv(f, a, b);
    issue(f, a, b);
    wait_result(name, r[63:32], r[31:0], noise);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, expected all zero", bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(negedge clock);
    reset = 1'b0;
    check_hold("reset_release", 32'h0, 32'h0);
  endtask

  task automatic test_decode();
    logic [7:0] din [10];
    logic [4:0] dex [10];
    logic [4:0] got, exp;
    logic [1:0] aop;
    logic [5:0] f;
    din = '{{2'b10, 6'b100000}, {2'b10, 6'b100010}, {2'b10, 6'b100100}, {2'b10, 6'b100101},
            {2'b10, 6'b101010}, {2'b10, 6'b000111}, {2'b11, 6'b100000}, {2'b00, 6'b000111},
            {2'b01, 6'b111111}, {2'b10, 6'b011010}};
    dex = '{5'b0_0010, 5'b0_0110, 5'b0_0000, 5'b0_0001, 5'b0_0111,
            5'b1_1111, 5'b1_1111, 5'b0_0010, 5'b0_0110, 5'b0_0010};
    bus.start = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      bus.ALUOP = din[i][7:6];
      bus.funct = din[i][5:0];
      #1;
      got = {bus.illegal, bus.alu_ctrl};
      checks++;
      if (got !== dex[i]) begin
        errors++;
        $display("FAIL decode_dir aluop=%b funct=%b: got ill/sel=%b expected %b", din[i][7:6], din[i][5:0], got, dex[i]);
      end
    end
    for (int unsigned i = 0; i < 200; i++) begin
      aop = 2'($urandom_range(0, 3));
      f   = (i % 4 == 0) ? {2'b10, 4'($urandom_range(0, 15))} : 6'($urandom_range(0, 63));
      bus.ALUOP = aop;
      bus.funct = f;
      #1;
      exp = ref_dec(aop, f);
      got = {bus.illegal, bus.alu_ctrl};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL decode_rand aluop=%b funct=%b: got ill/sel=%b expected %b", aop, f, got, exp);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_multu_timing();
    issue(6'b011001, 32'hFFFF_FFFF, 32'h2);
    wait_result("multu_max_x2", 32'h1, 32'hFFFF_FFFE, 1'b1);
    check_hold("multu_max_x2", 32'h1, 32'hFFFF_FFFE);
  endtask

  task automatic test_divu();
    issue(6'b011011, 32'd7, 32'd2);
    wait_result("divu_7_2", 32'd1, 32'd3, 1'b0);
    check_hold("divu_7_2", 32'd1, 32'd3);
    issue(6'b011011, 32'd5, 32'd0);
    wait_result("divu_5_0", 32'd5, 32'hFFFF_FFFF, 1'b0);
    check_hold("divu_5_0", 32'd5, 32'hFFFF_FFFF);
    // Non-mul/div funct with start must not launch an op
    bus.ALUOP = 2'b10;
    bus.funct = 6'b100000;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_non_muldiv: busy=%b expected 0", bus.busy);
    end
    check_hold("start_non_muldiv", 32'd5, 32'hFFFF_FFFF);
  endtask

  task automatic test_signed();
    if (SIGNED_EN) begin
      issue(6'b011010, 32'hFFFF_FFF9, 32'd2);
      wait_result("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      issue(6'b011000, 32'hFFFF_FFFD, 32'd4);
      wait_result("mult_m3_4", 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0);
    end else begin
      issue(6'b011010, 32'hFFFF_FFF9, 32'd2);
      wait_result("div_m7_2", 32'h1, 32'h7FFF_FFFC, 1'b0);
      issue(6'b011000, 32'hFFFF_FFFD, 32'd4);
      wait_result("mult_m3_4", 32'h3, 32'hFFFF_FFF4, 1'b0);
    end
    issue(6'b011010, 32'hFFFF_FFF9, 32'd0);
    wait_result("div_m7_0", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
    check_hold("div_m7_0", 32'hFFFF_FFF9, 32'hFFFF_FFFF);
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    model_op("b2b_0", 6'b011001, $urandom, $urandom, 1'b0, r);
    model_op("b2b_1", 6'b011011, $urandom, 32'($urandom_range(1, 1000)), 1'b1, r);
    model_op("b2b_2", 6'b011000, $urandom, $urandom, 1'b0, r);
    check_hold("b2b_end", r[63:32], r[31:0]);
  endtask

  task automatic test_random();
    logic [63:0] r;
    logic [5:0]  f;
    logic [31:0] a, b;
    for (int unsigned i = 0; i < 20; i++) begin
      f = {4'b0110, 2'($urandom_range(0, 3))};
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'($urandom_range(0, 40)); b = 32'($urandom_range(1, 9)); end
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      model_op("random", f, a, b, (i % 2) == 1, r);
      if (i % 3 == 0) check_hold("random", r[63:32], r[31:0]);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_midop();
    logic [63:0] r;
    int          pulses;
    issue(6'b011011, 32'h1234_1234, 32'h0001_0000);
    wait_result("preload_1234", 32'h1234, 32'h1234, 1'b0);
    issue(6'b011001, $urandom, $urandom);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_midop: busy=%b done=%b hi=%h lo=%h, expected all zero", bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort: %0d busy/done cycles hi=%h lo=%h, expected 0 cycles and zero hi/lo", pulses, bus.hi, bus.lo);
    end
    model_op("after_reset", 6'b011001, $urandom, $urandom, 1'b0, r);
    check_hold("after_reset", r[63:32], r[31:0]);
  endtask

  initial begin
    bus.ALUOP = 2'b00;
    bus.funct = 6'b0;
    bus.start = 1'b0;
    bus.op_a  = 32'h0;
    bus.op_b  = 32'h0;
    test_reset();
    test_decode();
    test_multu_timing();
    test_divu();
    test_signed();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
